// File: rtl/tdd_frame_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tdd_frame_sched
//  Description : TDD frame scheduler in the sample clock domain. Keeps a
//                per-frame sample counter and decodes the RX/TX windows and
//                the RF direction controls from it. Geometry and one-shot
//                length adjustments are latched on each frame boundary.
//  Revision    : 1.0 - initial release
// ============================================================================
module tdd_frame_sched #(
  parameter int CNT_W = 24
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             en,
  input  logic             ce,
  input  logic             sync,
  input  logic [CNT_W-1:0] frame_len,
  input  logic [CNT_W-1:0] rstart,
  input  logic [CNT_W-1:0] rend,
  input  logic [CNT_W-1:0] tstart,
  input  logic [CNT_W-1:0] tend,
  input  logic [CNT_W-1:0] frame_adj,
  input  logic             adj_req,
  output logic             adj_pending,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [31:0]      frame_num,
  output logic             frame_start,
  output logic             rx_en,
  output logic             tx_en,
  output logic             tx_rx,
  output logic             pa_en,
  output logic             rf_sw
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Two guard bits: one for overflow above the counter range, one for sign.
  localparam int SW = CNT_W + 2;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      num_q, num_d;
  logic             fs_q, fs_d;
  logic             rx_q, rx_d;
  logic             tx_q, tx_d;
  logic             pend_q, pend_d;
  logic [CNT_W-1:0] adj_q, adj_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] rs_q, rs_d, re_q, re_d;
  logic [CNT_W-1:0] ts_q, ts_d, te_q, te_d;

  logic [SW-1:0]    sum_w;
  logic [CNT_W-1:0] len_w;
  logic             rxw_w, txw_w;

  // Half-open window test; start > end wraps across the frame boundary.
  function automatic logic in_win(input logic [CNT_W-1:0] c,
                                  input logic [CNT_W-1:0] s,
                                  input logic [CNT_W-1:0] e);
    if (s < e)      return (c >= s) && (c < e);
    else if (s > e) return (c >= s) || (c < e);
    else            return 1'b0;
  endfunction

  // Length of the frame about to start: nominal plus pending delta, clamped.
  always_comb begin
    sum_w = {2'b00, frame_len};
    if (pend_q) sum_w = sum_w + {{2{adj_q[CNT_W-1]}}, adj_q};
    if (sum_w[SW-1] || (!sum_w[CNT_W] && (sum_w[CNT_W-1:0] < CNT_W'(2))))
      len_w = CNT_W'(2);
    else if (sum_w[CNT_W])
      len_w = '1;
    else
      len_w = sum_w[CNT_W-1:0];
  end

  // Next-state logic: sequencing, boundary handling and window decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    num_d   = num_q;
    fs_d    = 1'b0;
    len_d   = len_q;
    rs_d    = rs_q;
    re_d    = re_q;
    ts_d    = ts_q;
    te_d    = te_q;
    pend_d  = pend_q;
    adj_d   = adj_q;
    rxw_w   = 1'b0;
    txw_w   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (en && ce) begin
          // First frame: counts as a boundary but is not numbered as a new one.
          state_d = ST_RUN;
          fs_d    = 1'b1;
        end
      end
      default: begin
        if (!en) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (sync || (ce && (cnt_q == len_q - CNT_W'(1)))) begin
          fs_d  = 1'b1;
          num_d = num_q + 32'd1;
        end else if (ce) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    endcase

    if (fs_d) begin
      cnt_d = '0;
      len_d = len_w;
      rs_d  = rstart;
      re_d  = rend;
      ts_d  = tstart;
      te_d  = tend;
      pend_d = 1'b0;
    end

    // A request on the boundary clock survives to the following boundary.
    if (adj_req) begin
      pend_d = 1'b1;
      adj_d  = frame_adj;
    end

    if (state_d == ST_RUN) begin
      rxw_w = in_win(cnt_d, rs_d, re_d);
      txw_w = in_win(cnt_d, ts_d, te_d);
    end
    tx_d = txw_w;
    rx_d = rxw_w & ~txw_w;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      num_q   <= '0;
      fs_q    <= 1'b0;
      rx_q    <= 1'b0;
      tx_q    <= 1'b0;
      pend_q  <= 1'b0;
      adj_q   <= '0;
      len_q   <= CNT_W'(2);
      rs_q    <= '0;
      re_q    <= '0;
      ts_q    <= '0;
      te_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      num_q   <= num_d;
      fs_q    <= fs_d;
      rx_q    <= rx_d;
      tx_q    <= tx_d;
      pend_q  <= pend_d;
      adj_q   <= adj_d;
      len_q   <= len_d;
      rs_q    <= rs_d;
      re_q    <= re_d;
      ts_q    <= ts_d;
      te_q    <= te_d;
    end
  end

  assign adj_pending = pend_q;
  assign frame_cnt   = cnt_q;
  assign frame_num   = num_q;
  assign frame_start = fs_q;
  assign rx_en       = rx_q;
  assign tx_en       = tx_q;
  assign tx_rx       = tx_q;
  assign pa_en       = tx_q;
  assign rf_sw       = tx_q;

endmodule
`default_nettype wire

// File: tb/tb_tdd_frame_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tdd_frame_sched
//  Description : Directed self-checking bench for tdd_frame_sched.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tdd_frame_sched;

  localparam int CNT_W = 24;

  logic             clk = 1'b0;
  logic             nrst;
  logic             en, ce, sync, adj_req;
  logic [CNT_W-1:0] frame_len, rstart, rend, tstart, tend, frame_adj;
  logic             adj_pending, frame_start, rx_en, tx_en, tx_rx, pa_en, rf_sw;
  logic [CNT_W-1:0] frame_cnt;
  logic [31:0]      frame_num;

  int n_vec = 0;
  int n_err = 0;

  tdd_frame_sched #(.CNT_W(CNT_W)) dut (
    .clk(clk), .nrst(nrst), .en(en), .ce(ce), .sync(sync),
    .frame_len(frame_len), .rstart(rstart), .rend(rend),
    .tstart(tstart), .tend(tend), .frame_adj(frame_adj), .adj_req(adj_req),
    .adj_pending(adj_pending), .frame_cnt(frame_cnt), .frame_num(frame_num),
    .frame_start(frame_start), .rx_en(rx_en), .tx_en(tx_en),
    .tx_rx(tx_rx), .pa_en(pa_en), .rf_sw(rf_sw)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Counter, number, strobe and all window outputs in one go.
  task automatic chk_all(input string tag, input int c, input int f, input logic fs,
                         input logic rx, input logic tx);
    chk({tag, ".cnt"},   32'(frame_cnt), 32'(c));
    chk({tag, ".num"},   frame_num, 32'(f));
    chk({tag, ".fs"},    32'(frame_start), 32'(fs));
    chk({tag, ".rx"},    32'(rx_en), 32'(rx));
    chk({tag, ".tx"},    32'(tx_en), 32'(tx));
    chk({tag, ".txrx"},  32'(tx_rx), 32'(tx));
    chk({tag, ".pa"},    32'(pa_en), 32'(tx));
    chk({tag, ".rfsw"},  32'(rf_sw), 32'(tx));
  endtask

  // Hand-written windows: frames 0-2 RX[0,4) TX[5,9); 3-4 RX[3,6) TX[8,2); 5 RX[0,7) TX[4,8).
  function automatic logic exp_rx(input int f, input int c);
    if (f <= 2)      return c < 4;
    else if (f <= 4) return (c >= 3) && (c < 6);
    else             return c < 4;
  endfunction

  function automatic logic exp_tx(input int f, input int c);
    if (f <= 2)      return (c >= 5) && (c <= 8);
    else if (f <= 4) return (c >= 8) || (c < 2);
    else             return (c >= 4) && (c <= 7);
  endfunction

  // One frame of given length; optional adjust pulse while the count shows adj_at.
  task automatic run_frame(input int f, input int len, input int adj_at, input int adj_val);
    for (int i = 0; i < len; i++) begin
      step();
      adj_req = 1'b0;
      chk("adj.cnt",  32'(frame_cnt), 32'(i));
      chk("adj.num",  frame_num, 32'(f));
      chk("adj.fs",   32'(frame_start), 32'(i == 0));
      chk("adj.pend", 32'(adj_pending), 32'((adj_at >= 0) && (i > adj_at)));
      if (i == adj_at) begin
        frame_adj = adj_val[CNT_W-1:0];
        adj_req   = 1'b1;
      end
    end
  endtask

  initial begin
    int ec, en_num;
    nrst = 1'b0; en = 1'b0; ce = 1'b0; sync = 1'b0; adj_req = 1'b0;
    frame_len = 24'd10; rstart = 24'd0; rend = 24'd4; tstart = 24'd5; tend = 24'd9;
    frame_adj = '0;
    #12;
    chk_all("reset", 0, 0, 1'b0, 1'b0, 1'b0);
    chk("reset.pend", 32'(adj_pending), 32'd0);
    #10;
    nrst = 1'b1;
    en = 1'b1;
    ce = 1'b1;

    // Basic, wrapping and overlapping windows over six frames.
    for (int k = 0; k < 60; k++) begin
      step();
      chk_all("win", k % 10, k / 10, (k % 10) == 0, exp_rx(k / 10, k % 10), exp_tx(k / 10, k % 10));
      if (k == 25) begin rstart = 24'd3; rend = 24'd6; tstart = 24'd8; tend = 24'd2; end
      if (k == 45) begin rstart = 24'd0; rend = 24'd7; tstart = 24'd4; tend = 24'd8; end
    end

    // Adjust -3 -> 7-sample frame, then -20 clamps to 2 samples.
    run_frame(6, 10, 5, -3);
    run_frame(7, 7, -1, 0);
    run_frame(8, 10, 2, -20);
    run_frame(9, 2, -1, 0);
    run_frame(10, 10, -1, 0);

    // Strobe every 4th clock, then sync with ce low.
    for (int j = 0; j < 25; j++) begin
      ce   = (j % 4) == 3;
      sync = (j == 24);
      step();
      if (j < 3)       begin ec = 9;           en_num = 10; end
      else if (j < 24) begin ec = (j - 3) / 4; en_num = 11; end
      else             begin ec = 0;           en_num = 12; end
      chk("ce.cnt", 32'(frame_cnt), 32'(ec));
      chk("ce.num", frame_num, 32'(en_num));
      chk("ce.fs",  32'(frame_start), 32'((j == 3) || (j == 24)));
    end
    sync = 1'b0;
    ce   = 1'b1;

    // Sync coinciding with the natural wrap counts once.
    for (int i = 1; i < 10; i++) begin
      step();
      chk("pre.cnt", 32'(frame_cnt), 32'(i));
      chk("pre.num", frame_num, 32'd12);
    end
    sync = 1'b1;
    step();
    sync = 1'b0;
    chk_all("syncwrap", 0, 13, 1'b1, 1'b1, 1'b0);
    step();
    chk_all("postwrap", 1, 13, 1'b0, 1'b1, 1'b0);

    // Stop with TX active at cnt 6.
    for (int i = 2; i < 7; i++) begin
      step();
      chk_all("run", i, 13, 1'b0, i < 4, i >= 4);
    end
    en = 1'b0;
    step();
    chk_all("stop", 0, 13, 1'b0, 1'b0, 1'b0);
    step();
    chk_all("idle", 0, 13, 1'b0, 1'b0, 1'b0);

    // Restart does not bump frame_num.
    en = 1'b1;
    step();
    chk_all("restart", 0, 13, 1'b1, 1'b1, 1'b0);
    step();
    step();
    chk_all("run2", 2, 13, 1'b0, 1'b1, 1'b0);

    // Asynchronous reset mid-frame.
    #3;
    nrst = 1'b0;
    #1;
    chk_all("arst", 0, 0, 1'b0, 1'b0, 1'b0);
    chk("arst.pend", 32'(adj_pending), 32'd0);
    #10;
    en   = 1'b0;
    nrst = 1'b1;
    step();
    chk_all("post_rst", 0, 0, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tdd_frame_sched.md
# tdd_frame_sched

TDD frame scheduler for the AD9361 sample path. It runs in the sample clock (Sclk) domain and keeps a per-frame sample counter. From that counter it generates the receive/transmit enables that gate the AXI2S `Ien`/`Oen` paths, plus the AD9361/RF direction controls (`tx_rx`, `pa_en`, `rf_sw`). Frame geometry and one-shot frame-length adjustments come from the register space over the control bus; the block owns all sequencing.

## Interface
- `CNT_W`, default 24: width of the frame counter and of all geometry inputs.
- `clk` in 1: Sclk, the sample clock. One clock only.
- `nrst` in 1: asynchronous, active-low reset.
- `en` in 1: scheduler enable, level.
- `ce` in 1: sample strobe; the counter advances only on `ce`=1.
- `sync` in 1: one-clock pulse that forces a frame boundary.
- `frame_len` in CNT_W: nominal frame length in samples.
- `rstart`, `rend` in CNT_W each: RX window, half-open [start,end).
- `tstart`, `tend` in CNT_W each: TX window, half-open [start,end).
- `frame_adj` in CNT_W: signed one-shot length delta.
- `adj_req` in 1: one-clock pulse that captures `frame_adj`.
- `adj_pending` out 1: an adjustment is latched and not yet applied.
- `frame_cnt` out CNT_W: current sample index within the frame.
- `frame_num` out 32: frame counter, wraps modulo 2^32.
- `frame_start` out 1: one-clock pulse on each frame boundary.
- `rx_en` out 1: RX window active; ANDed into `Ien`.
- `tx_en` out 1: TX window active; ANDed into `Oen`.
- `tx_rx` out 1: AD9361 TXNRX; equals `tx_en`.
- `pa_en` out 1: PA enable; equals `tx_en`.
- `rf_sw` out 1: T/R switch, 1 = TX; equals `tx_en`.

## Operation
- States:
  - IDLE: all outputs 0 except `frame_num` and `adj_pending`, which hold.
  - RUN: the frame counter is active.
- IDLE to RUN:
  - Trigger: `en`=1 on a clock with `ce`=1.
  - On the next clock: `frame_cnt`=0, `frame_start`=1, geometry latched.
  - `frame_num` does not increment on this first frame.
- RUN to IDLE:
  - Trigger: `en`=0, checked every clock.
  - Next clock: all window outputs 0, `frame_cnt`=0. No frame completion.
- RUN, `ce`=1, `frame_cnt` < L-1: `frame_cnt`+1.
- RUN, `ce`=1, `frame_cnt` = L-1: frame boundary.
- RUN, `sync`=1 (any `ce`): frame boundary on the next clock.
- Frame boundary:
  - `frame_cnt`=0, `frame_num`+1, `frame_start`=1.
  - Relatch `frame_len`, `rstart`, `rend`, `tstart` and `tend`. Geometry changes mid-frame have no effect until the next boundary.
  - If `adj_pending`, this frame uses L = `frame_len` + signed `frame_adj`, and `adj_pending` clears. Otherwise L = `frame_len`.
  - L is clamped to a minimum of 2. A `frame_len` below 2 is treated as 2.
  - `sync` and a natural wrap on the same clock: one boundary, `frame_num`+1 once.
- Adjust:
  - `adj_req` captures `frame_adj` and sets `adj_pending`.
  - A new request while pending overwrites the value; latest wins.
  - `adj_req` on the boundary clock is applied at the following boundary.
- Window decode, evaluated against latched values:
  - start < end: active when start ≤ cnt < end.
  - start > end: wrapping window, active when cnt ≥ start or cnt < end.
  - start = end: never active.
  - Window values ≥ L are never reached by cnt, so those positions never activate.
- Priority: TX wins. `rx_en` = RX window & ~TX window.

## Timing
- Reset values: every output is 0, including `frame_num` and `adj_pending`; state is IDLE.
- All outputs are registered.
- Window outputs are decoded from the next-count value, so they align with the `frame_cnt` shown on the same clock. There is zero latency between the count and its enables.
- `frame_start` is high exactly on the clock where `frame_cnt` first shows 0.
- `adj_pending` rises on the clock after `adj_req`. It falls on the same clock that `frame_start` rises for the adjusted frame.
- With `ce` stuck at 0 in RUN, outputs hold. `sync` still acts.
- Asserting `nrst` mid-frame takes effect immediately and asynchronously: outputs go to 0. After release the block is in IDLE.

## Test plan
- Basic frame: `frame_len`=10, RX [0,4), TX [5,9), `ce`=1.
  - `rx_en` on cnt 0–3; `tx_en`/`tx_rx`/`pa_en`/`rf_sw` on cnt 5–8; idle at cnt 4 and 9.
  - `frame_start` every 10 clocks; `frame_num` runs 0,1,2.
- Wrapping window: len 10, TX [8,2) → `tx_en` on cnt 8,9,0,1 across the boundary.
- Overlap: RX [0,7), TX [4,8) → `rx_en` on cnt 0–3, `tx_en` on cnt 4–7, never both high.
- Adjust: `frame_adj`=-3 pulsed at cnt 5.
  - `adj_pending` is 1 until the next boundary.
  - The next frame is 7 samples, the one after is 10.
  - `frame_adj`=-20 clamps that frame to 2 samples.
- Strobe and sync: `ce` every 4th clock → `frame_cnt` steps once per 4 clocks. `sync` at cnt 5 → cnt 0 on the next clock, `frame_num`+1. `sync` coincident with cnt 9 wrap → a single +1.
- Stop and reset: `en` falls at cnt 6 with TX active → next clock all enables 0, IDLE, `frame_num` held. `nrst` low mid-frame → all outputs 0 immediately.
